// File: rtl/daisy_chain_input_reader_pkg.sv
// Shared constants for the daisy-chain input reader: register map, bit positions,
// scan FSM encoding and parameter range limiting.
package daisy_chain_input_reader_pkg;

  localparam int unsigned MaxBytes  = 4;
  localparam int unsigned MinClkDiv = 4;

  localparam logic AddrData = 1'b0;
  localparam logic AddrCtrl = 1'b1;

  localparam int unsigned StatusEnableBit = 0;
  localparam int unsigned StatusNewBit    = 1;
  localparam int unsigned StatusBusyBit   = 2;

  localparam int unsigned CtrlEnableBit = 0;
  localparam int unsigned CtrlStartBit  = 1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StCapture
  } scan_state_e;

  // Out-of-range chain lengths fall back to the largest supported chain.
  function automatic int unsigned legal_num_bytes(input int unsigned n);
    return ((n >= 1) && (n <= MaxBytes)) ? n : MaxBytes;
  endfunction

  function automatic int unsigned legal_clk_div(input int unsigned d);
    return (d >= MinClkDiv) ? d : MinClkDiv;
  endfunction

endpackage

// File: rtl/daisy_chain_input_reader_shift_in.sv
// Scan engine: pulses parallel-load, clocks the chain and shifts synchronized serial data
// into a shift register, reporting busy and a one-cycle done pulse.
module daisy_chain_shift_in
  import daisy_chain_input_reader_pkg::*;
#(
  parameter int unsigned NumBytes = 4,
  parameter int unsigned ClkDiv   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    enable_i,
  input  logic                    sr_data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    sr_load_n_o,
  output logic                    sr_clk_o,
  output logic [8*NumBytes-1:0]   data_o
);

  localparam int unsigned NumBits = 8 * NumBytes;
  localparam int unsigned DivW    = $clog2(ClkDiv);
  localparam int unsigned BitW    = $clog2(NumBits);
  localparam logic [DivW-1:0] DivLast = DivW'(ClkDiv - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(NumBits - 1);

  scan_state_e          state_q, state_d;
  logic [DivW-1:0]      div_q, div_d;
  logic [BitW-1:0]      bit_q, bit_d;
  logic                 phase_q, phase_d;
  logic [NumBits-1:0]   shreg_q, shreg_d;
  logic [1:0]           sync_q, sync_d;
  logic                 pend_q, pend_d;
  logic                 load_n_q, load_n_d;
  logic                 sr_clk_q, sr_clk_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    pend_d  = pend_q;
    sync_d  = {sync_q[0], sr_data_i};

    unique case (state_q)
      StIdle: begin
        if (enable_i || pend_q) begin
          state_d = StLoad;
          pend_d  = 1'b0;
          div_d   = '0;
        end else if (start_i) begin
          pend_d = 1'b1;
        end
      end
      StLoad: begin
        if (div_q == DivLast) begin
          state_d = StShift;
          div_d   = '0;
          bit_d   = '0;
          phase_d = 1'b0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StShift: begin
        if (div_q != DivLast) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!phase_q) begin
            // End of the low phase: data has been stable since the previous rising edge.
            phase_d = 1'b1;
            shreg_d = {shreg_q[NumBits-2:0], sync_q[1]};
          end else begin
            phase_d = 1'b0;
            if (bit_q == BitLast) begin
              state_d = StCapture;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      StCapture: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // Chain outputs are registered from the next state so they align with state_q.
    load_n_d = (state_d != StLoad);
    sr_clk_d = (state_d == StShift) && phase_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      div_q    <= '0;
      bit_q    <= '0;
      phase_q  <= 1'b0;
      shreg_q  <= '0;
      sync_q   <= '0;
      pend_q   <= 1'b0;
      load_n_q <= 1'b1;
      sr_clk_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      phase_q  <= phase_d;
      shreg_q  <= shreg_d;
      sync_q   <= sync_d;
      pend_q   <= pend_d;
      load_n_q <= load_n_d;
      sr_clk_q <= sr_clk_d;
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = (state_q == StCapture);
  assign sr_load_n_o = load_n_q;
  assign sr_clk_o    = sr_clk_q;
  assign data_o      = shreg_q;

endmodule

// File: rtl/daisy_chain_input_reader_avalon_interface.sv
// Avalon-MM slave wrapper: register decode, snapshot word, new flag and the
// latency-1 read data register around the shift-in scan engine.
module daisy_chain_input_reader_avalon_interface
  import daisy_chain_input_reader_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4,
  parameter int unsigned CLK_DIV   = 8,
  parameter bit          AUTO_SCAN = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        avs_s0_chipselect,
  input  logic        avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [3:0]  avs_s0_byteenable,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  output logic        sr_load_n_export,
  output logic        sr_clk_export,
  input  logic        sr_data_export
);

  localparam int unsigned NumBytesL = legal_num_bytes(NUM_BYTES);
  localparam int unsigned ClkDivL   = legal_clk_div(CLK_DIV);

  logic                     busy, done, start;
  logic [8*NumBytesL-1:0]   scan_data;
  logic                     rd_acc, wr_ctrl;
  logic [31:0]              status;

  logic [31:0] snapshot_q, snapshot_d;
  logic [31:0] readdata_q, readdata_d;
  logic        new_q, new_d;
  logic        enable_q, enable_d;

  daisy_chain_shift_in #(
    .NumBytes (NumBytesL),
    .ClkDiv   (ClkDivL)
  ) u_shift_in (
    .clk_i       (clock),
    .rst_i       (reset),
    .start_i     (start),
    .enable_i    (enable_q),
    .sr_data_i   (sr_data_export),
    .busy_o      (busy),
    .done_o      (done),
    .sr_load_n_o (sr_load_n_export),
    .sr_clk_o    (sr_clk_export),
    .data_o      (scan_data)
  );

  always_comb begin
    rd_acc  = avs_s0_chipselect && avs_s0_read;
    wr_ctrl = avs_s0_chipselect && avs_s0_write && (avs_s0_address == AddrCtrl) &&
              avs_s0_byteenable[0];
    start   = wr_ctrl && avs_s0_writedata[CtrlStartBit];

    status                  = '0;
    status[StatusEnableBit] = enable_q;
    status[StatusNewBit]    = new_q;
    status[StatusBusyBit]   = busy;

    enable_d   = wr_ctrl ? avs_s0_writedata[CtrlEnableBit] : enable_q;
    snapshot_d = done ? 32'(scan_data) : snapshot_q;

    // A capture in the same cycle as a DATA read leaves the flag set.
    new_d = new_q;
    if (rd_acc && (avs_s0_address == AddrData)) new_d = 1'b0;
    if (done) new_d = 1'b1;

    readdata_d = readdata_q;
    if (rd_acc) readdata_d = (avs_s0_address == AddrData) ? snapshot_q : status;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snapshot_q <= '0;
      readdata_q <= '0;
      new_q      <= 1'b0;
      enable_q   <= AUTO_SCAN;
    end else begin
      snapshot_q <= snapshot_d;
      readdata_q <= readdata_d;
      new_q      <= new_d;
      enable_q   <= enable_d;
    end
  end

  assign avs_s0_readdata = readdata_q;

endmodule

// File: tb/tb_daisy_chain_input_reader_avalon_interface.sv
// Bench: two instances (32-bit and 8-bit chains) each driven by a 74HC165-style chain model.
module tb_daisy_chain_input_reader_avalon_interface;

  localparam int unsigned Nb0 = 4;
  localparam int unsigned Cd0 = 8;
  localparam int unsigned Nb1 = 1;
  localparam int unsigned Cd1 = 4;
  localparam int unsigned Scan0 = Cd0 * (1 + 16 * Nb0) + 2;
  localparam int unsigned Scan1 = Cd1 * (1 + 16 * Nb1) + 2;
  localparam int unsigned CapOff0 = Cd0 * (1 + 16 * Nb0);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        cs [2];
  logic        rd [2];
  logic        wr [2];
  logic        addr [2];
  logic [3:0]  be [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        load_n [2];
  logic        sclk [2];
  logic        sdata [2];

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  daisy_chain_input_reader_avalon_interface #(
    .NUM_BYTES (Nb0), .CLK_DIV (Cd0), .AUTO_SCAN (1'b1)
  ) u_dut0 (
    .clock (clock), .reset (reset),
    .avs_s0_chipselect (cs[0]), .avs_s0_address (addr[0]), .avs_s0_read (rd[0]),
    .avs_s0_write (wr[0]), .avs_s0_byteenable (be[0]), .avs_s0_writedata (wdata[0]),
    .avs_s0_readdata (rdata[0]), .sr_load_n_export (load_n[0]), .sr_clk_export (sclk[0]),
    .sr_data_export (sdata[0])
  );

  daisy_chain_input_reader_avalon_interface #(
    .NUM_BYTES (Nb1), .CLK_DIV (Cd1), .AUTO_SCAN (1'b0)
  ) u_dut1 (
    .clock (clock), .reset (reset),
    .avs_s0_chipselect (cs[1]), .avs_s0_address (addr[1]), .avs_s0_read (rd[1]),
    .avs_s0_write (wr[1]), .avs_s0_byteenable (be[1]), .avs_s0_writedata (wdata[1]),
    .avs_s0_readdata (rdata[1]), .sr_load_n_export (load_n[1]), .sr_clk_export (sclk[1]),
    .sr_data_export (sdata[1])
  );

  // Chain models: parallel load while load_n is low, shift toward the MSB on each sr_clk rise.
  logic [31:0] chain_val0 = 32'h0;
  logic [31:0] chain0 = 32'h0;
  logic [7:0]  chain_val1 = 8'h0;
  logic [7:0]  chain1 = 8'h0;
  logic        sclk_prev0 = 1'b0;
  logic        sclk_prev1 = 1'b0;
  int unsigned rises0 = 0;
  int unsigned rises1 = 0;
  int unsigned load_len = 0;
  int unsigned last_load_len = 0;

  always @(posedge clock) begin
    sclk_prev0 <= sclk[0];
    sclk_prev1 <= sclk[1];
    if (!load_n[0]) chain0 <= chain_val0;
    else if (sclk[0] && !sclk_prev0) chain0 <= {chain0[30:0], 1'b0};
    if (!load_n[1]) chain1 <= chain_val1;
    else if (sclk[1] && !sclk_prev1) chain1 <= {chain1[6:0], 1'b0};
    if (sclk[0] && !sclk_prev0) rises0 <= rises0 + 1;
    if (sclk[1] && !sclk_prev1) rises1 <= rises1 + 1;
    if (!load_n[0]) load_len <= load_len + 1;
    else if (load_len != 0) begin
      last_load_len <= load_len;
      load_len      <= 0;
    end
  end

  assign sdata[0] = chain0[31];
  assign sdata[1] = chain1[7];

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_read(input int d, input logic a, output logic [31:0] data);
    cs[d] = 1'b1; rd[d] = 1'b1; addr[d] = a;
    tick(1);
    cs[d] = 1'b0; rd[d] = 1'b0;
    data = rdata[d];
  endtask

  task automatic bus_write(input int d, input logic a, input logic [3:0] b, input logic [31:0] v);
    cs[d] = 1'b1; wr[d] = 1'b1; addr[d] = a; be[d] = b; wdata[d] = v;
    tick(1);
    cs[d] = 1'b0; wr[d] = 1'b0; be[d] = 4'h0;
  endtask

  task automatic wait_load_low(input int d, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (load_n[d] == 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    chain_val0 = 32'hA5C3_0F81;
    reset = 1'b1;
    tick(3);
    n_cmp++;
    if (load_n[0] !== 1'b1 || sclk[0] !== 1'b0 || rdata[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: load_n=%b sclk=%b rdata=%h, want 1 0 0",
               load_n[0], sclk[0], rdata[0]);
    end
    reset = 1'b0;
    tick(Scan0);
    bus_read(0, 1'b1, v);
    n_cmp++;
    if (v !== 32'h3) begin
      n_fail++;
      $display("FAIL auto_status: got %h want %h", v, 32'h3);
    end
    bus_read(0, 1'b0, v);
    n_cmp++;
    if (v !== 32'hA5C3_0F81) begin
      n_fail++;
      $display("FAIL auto_data: got %h want %h", v, 32'hA5C3_0F81);
    end
    n_cmp++;
    if (last_load_len !== Cd0) begin
      n_fail++;
      $display("FAIL load_len: got %0d want %0d", last_load_len, Cd0);
    end
  endtask

  task automatic test_single_start();
    logic [31:0] v;
    int unsigned base;
    bus_write(0, 1'b1, 4'h1, 32'h0);
    tick(Scan0 + 4);
    base = rises0;
    chain_val0 = $urandom;
    bus_write(0, 1'b1, 4'h1, 32'h2);
    tick(20);
    bus_write(0, 1'b1, 4'h1, 32'h2);
    tick(2 * Scan0);
    n_cmp++;
    if (rises0 - base !== 32) begin
      n_fail++;
      $display("FAIL start_edges: got %0d want 32", rises0 - base);
    end
    bus_read(0, 1'b1, v);
    n_cmp++;
    if (v !== 32'h2) begin
      n_fail++;
      $display("FAIL start_status: got %h want %h", v, 32'h2);
    end
  endtask

  task automatic test_read_clears_new();
    logic [31:0] v;
    bus_read(0, 1'b0, v);
    n_cmp++;
    if (v !== chain_val0) begin
      n_fail++;
      $display("FAIL clear_data: got %h want %h", v, chain_val0);
    end
    bus_read(0, 1'b1, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_status: got %h want %h", v, 32'h0);
    end
  endtask

  task automatic test_random_scans();
    logic [31:0] v;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      chain_val0 = $urandom;
      bus_write(0, 1'b1, 4'h1, 32'h2);
      wait_load_low(0, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL rand_load_timeout: got no load pulse want one");
      end
      tick(Scan0);
      bus_read(0, 1'b0, v);
      n_cmp++;
      if (v !== chain_val0) begin
        n_fail++;
        $display("FAIL rand_data[%0d]: got %h want %h", k, v, chain_val0);
      end
    end
  endtask

  task automatic test_capture_collision();
    logic [31:0] v;
    logic [31:0] old;
    bit ok;
    old = chain_val0;
    chain_val0 = old ^ ($urandom | 32'h1);
    bus_write(0, 1'b1, 4'h1, 32'h2);
    wait_load_low(0, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL coll_load_timeout: got no load pulse want one");
    end
    tick(CapOff0);
    bus_read(0, 1'b0, v);
    n_cmp++;
    if (v !== old) begin
      n_fail++;
      $display("FAIL coll_old_data: got %h want %h", v, old);
    end
    tick(2);
    bus_read(0, 1'b1, v);
    n_cmp++;
    if (v !== 32'h2) begin
      n_fail++;
      $display("FAIL coll_status: got %h want %h", v, 32'h2);
    end
    bus_read(0, 1'b0, v);
    n_cmp++;
    if (v !== chain_val0) begin
      n_fail++;
      $display("FAIL coll_new_data: got %h want %h", v, chain_val0);
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [31:0] v;
    int unsigned base;
    bit ok;
    chain_val0 = $urandom | 32'h1;
    bus_write(0, 1'b1, 4'h1, 32'h2);
    wait_load_low(0, ok);
    base = rises0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (rises0 - base >= 17) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midscan_timeout: got %0d edges want 17", rises0 - base);
    end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    n_cmp++;
    if (sclk[0] !== 1'b0 || load_n[0] !== 1'b1 || rdata[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL midscan_outputs: sclk=%b load_n=%b rdata=%h, want 0 1 0",
               sclk[0], load_n[0], rdata[0]);
    end
    bus_read(0, 1'b0, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL midscan_snapshot: got %h want 0", v);
    end
    bus_read(0, 1'b1, v);
    n_cmp++;
    if (v[1:0] !== 2'b01) begin
      n_fail++;
      $display("FAIL midscan_status: got %b want 01", v[1:0]);
    end
  endtask

  task automatic test_small_chain();
    logic [31:0] v;
    int unsigned base;
    bit ok;
    for (int k = 0; k < 4; k++) begin
      chain_val1 = (k == 0) ? 8'h3C : 8'($urandom);
      bus_write(1, 1'b1, 4'h1, 32'h2);
      wait_load_low(1, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++;
        $display("FAIL small_load_timeout: got no load pulse want one");
      end
      tick(Scan1 + 2);
      bus_read(1, 1'b0, v);
      n_cmp++;
      if (v !== {24'h0, chain_val1}) begin
        n_fail++;
        $display("FAIL small_data[%0d]: got %h want %h", k, v, {24'h0, chain_val1});
      end
    end
    base = rises1;
    bus_write(1, 1'b1, 4'h0, 32'h3);
    bus_write(1, 1'b0, 4'hF, 32'h3);
    tick(2 * Scan1);
    bus_read(1, 1'b1, v);
    n_cmp++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL small_ignored_status: got %h want 0", v);
    end
    n_cmp++;
    if (rises1 !== base) begin
      n_fail++;
      $display("FAIL small_ignored_scan: got %0d edges want %0d", rises1, base);
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cs[d] = 1'b0; rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = 1'b0;
      be[d] = 4'h0; wdata[d] = 32'h0;
    end
    test_reset();
    test_single_start();
    test_read_clears_new();
    test_random_scans();
    test_capture_collision();
    test_reset_mid_scan();
    test_small_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
